uart_tx_arbiter: RTL and testbench

Shares one uart_tx instance among NUM_REQ requesters, e.g. the status reporter, the register echo path and debug dumpers. Each requester presents bytes over a valid/ready handshake and marks the final byte of its frame. The arbiter grants the transmitter round-robin, holds the grant for the whole frame, and drives the uart_tx tx_start/tx_data/tx_busy handshake. It sits between the requesters and uart_tx, inside com-style top levels.

---
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
//============================================================================
// Module : uart_tx_arbiter_if
// Desc   : Requester byte handshake plus uart_tx start/data/busy bundle.
// Rev    : 1.0  initial release
//============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int GW      = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [GW-1:0]        grant;
    logic                 active;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant, active
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant, active
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
//============================================================================
// Module : uart_tx_arbiter
// Desc   : Round-robin, frame-granular sharing of one uart_tx among NUM_REQ
//          byte requesters. Optional macro: UART_TX_ARB_WATCHDOG_EN.
// Rev    : 1.0  initial release
//============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int GW      = 2,
    parameter int TIMEOUT = 1200
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_START = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t       r_state;
    logic         r_tx_start;
    logic [7:0]   r_tx_data;
    logic [GW-1:0] r_grant;
    logic         r_active;
    logic [7:0]   r_byte;
    logic         r_last;

    logic               w_found;
    logic [GW-1:0]      w_winner;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [7:0]         w_sel_data;
    logic [NUM_REQ-1:0] w_ready;

`ifdef UART_TX_ARB_WATCHDOG_EN
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WDW-1:0] r_wd;
`else
    // TIMEOUT only sizes the watchdog, which this build leaves out
    if (TIMEOUT < 1) begin : g_no_watchdog
    end
`endif

    // First valid requester after the rr pointer; the last owner is scanned last
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && bus.req_valid[i] &&
                    (i == (int'(r_grant) + k) % NUM_REQ)) begin
                    w_found  = 1'b1;
                    w_winner = GW'(i);
                end
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        w_ready     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == GW'(i)) begin
                w_sel_valid = bus.req_valid[i];
                w_sel_last  = bus.req_last[i];
                w_sel_data  = bus.req_data[8*i +: 8];
                w_ready[i]  = (r_state == S_FETCH);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_grant    <= GW'(NUM_REQ - 1);
            r_active   <= 1'b0;
            r_byte     <= 8'h00;
            r_last     <= 1'b0;
`ifdef UART_TX_ARB_WATCHDOG_EN
            r_wd       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_active <= 1'b0;
                    if (w_found) begin
                        r_grant  <= w_winner;
                        r_active <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_sel_valid) begin
                        r_byte  <= w_sel_data;
                        r_last  <= w_sel_last;
                        r_state <= S_START;
`ifdef UART_TX_ARB_WATCHDOG_EN
                        r_wd    <= '0;
                    end else if (r_wd == WDW'(TIMEOUT - 1)) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                        r_wd     <= '0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
`endif
                    end
                end
                S_START: begin
                    // Never launch into a transmitter that is still shifting
                    if (!bus.tx_busy && !r_tx_start) begin
                        r_tx_data  <= r_byte;
                        r_tx_start <= 1'b1;
                    end else if (bus.tx_busy && r_tx_start) begin
                        r_tx_start <= 1'b0;
                        r_state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!bus.tx_busy) begin
                        if (r_last) begin
                            r_state  <= S_IDLE;
                            r_active <= 1'b0;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tx_start <= 1'b0;
                    r_active   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.tx_start  = r_tx_start;
    assign bus.tx_data   = r_tx_data;
    assign bus.grant     = r_grant;
    assign bus.active    = r_active;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
//============================================================================
// Module : tb_uart_tx_arbiter
// Desc   : Scoreboard bench: frames are queued per requester, the expected
//          uart byte stream is predicted by round-robin order over frames.
// Rev    : 1.0  initial release
//============================================================================
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int GW      = 2;
    localparam int TIMEOUT = 16;

    typedef struct { logic [7:0] data; logic last; } beat_t;
    typedef struct { int req; logic [7:0] data; } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .GW(GW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    beat_t                dq [NUM_REQ][$];
    logic [7:0]           fr [NUM_REQ][$];
    exp_t                 sb [$];
    logic [NUM_REQ-1:0]   drv_valid = '0;
    logic [NUM_REQ-1:0]   drv_last  = '0;
    logic [8*NUM_REQ-1:0] drv_data  = '0;
    int  gap_cnt [NUM_REQ];
    bit  gaps_en   = 1'b0;
    int  busy_len  = 10;
    int  force_cnt = 0;
    int  uart_cnt  = 0;
    int  rises     = 0;
    int  cyc       = 0;
    bit  mark_first = 1'b0;
    int  first_rise_cyc = 0;
    int  checks = 0;
    int  passed = 0;
    int  p = NUM_REQ - 1;

    assign bus.req_valid = drv_valid;
    assign bus.req_data  = drv_data;
    assign bus.req_last  = drv_last;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic make_frame(input int r, input int len);
        fr[r].delete();
        repeat (len) fr[r].push_back(8'($urandom));
    endtask

    // Reference: one frame per selected requester, served in ascending order after p
    task automatic commit(input logic [NUM_REQ-1:0] mask);
        int np;
        np = p;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int r;
            r = (p + k) % NUM_REQ;
            if (mask[r]) begin
                for (int b = 0; b < fr[r].size(); b++) begin
                    sb.push_back('{r, fr[r][b]});
                    dq[r].push_back('{fr[r][b], (b == fr[r].size() - 1)});
                end
                fr[r].delete();
                np = r;
            end
        end
        p = np;
    endtask

    // Everyone streaming 1-byte frames: strict rotation, p unchanged after full turns
    task automatic commit_rotation(input int n);
        for (int j = 0; j < n * NUM_REQ; j++) begin
            int r;
            logic [7:0] b;
            r = (p + 1 + j) % NUM_REQ;
            b = 8'($urandom);
            sb.push_back('{r, b});
            dq[r].push_back('{b, 1'b1});
        end
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() > 0 || bus.active || drv_valid != '0) && n < limit);
        check({name, " sb_left"}, sb.size(), 0);
        check({name, " active"}, int'(bus.active), 0);
        check({name, " grant"}, int'(bus.grant), p);
    endtask

    // Requester driver: handshake decided at negedge, consumed at the posedge
    initial begin
        logic [NUM_REQ-1:0] acc;
        for (int r = 0; r < NUM_REQ; r++) gap_cnt[r] = 0;
        forever begin
            @(negedge clk);
            acc = drv_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (acc[r] && dq[r].size() > 0) begin
                    if (gaps_en && !dq[r][0].last) gap_cnt[r] = $urandom_range(0, 3);
                    void'(dq[r].pop_front());
                end
                if (gap_cnt[r] > 0) begin
                    gap_cnt[r]--;
                    drv_valid[r] = 1'b0;
                end else if (dq[r].size() > 0) begin
                    drv_valid[r]         = 1'b1;
                    drv_data[8*r +: 8]   = dq[r][0].data;
                    drv_last[r]          = dq[r][0].last;
                end else begin
                    drv_valid[r] = 1'b0;
                end
                if (!drv_valid[r]) begin
                    drv_data[8*r +: 8] = 8'($urandom);
                    drv_last[r]        = 1'($urandom);
                end
            end
        end
    end

    // Monitor plus uart_tx busy model
    initial begin
        exp_t e;
        logic prev_start;
        int   width;
        prev_start  = 1'b0;
        width       = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.tx_start && !prev_start) begin
                rises++;
                width = 1;
                if (mark_first) begin
                    first_rise_cyc = cyc;
                    mark_first     = 1'b0;
                end
                check("start_vs_busy", int'(bus.tx_busy), 0);
                check("active_at_start", int'(bus.active), 1);
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("tx_data", int'(bus.tx_data), int'(e.data));
                    check("grant", int'(bus.grant), e.req);
                end
            end else if (bus.tx_start) begin
                width++;
            end
            if (!bus.tx_start && prev_start) check("start_width", width, 1);
            prev_start = bus.tx_start;
            if (force_cnt > 0) force_cnt--;
            if (uart_cnt > 0) uart_cnt--;
            else if (bus.tx_start && !bus.tx_busy) uart_cnt = busy_len;
            bus.tx_busy = (uart_cnt > 0) || (force_cnt > 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d checks at time limit, expected completion", checks);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n, r0, t0;
        #12;
        check("rst tx_start", int'(bus.tx_start), 0);
        check("rst tx_data", int'(bus.tx_data), 0);
        check("rst active", int'(bus.active), 0);
        check("rst grant", int'(bus.grant), NUM_REQ - 1);
        check("rst req_ready", int'(bus.req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;

        busy_len = 10;
        fr[0] = {8'h44, 8'h30, 8'h34, 8'h32, 8'h0A};
        commit(4'b0001);
        wait_done("single", 2000);

        make_frame(1, 2);
        make_frame(3, 2);
        commit(4'b1010);
        wait_done("contention", 2000);

        busy_len = 4;
        commit_rotation(2);
        wait_done("rotation", 2000);

        force_cnt  = 20;
        t0         = cyc;
        mark_first = 1'b1;
        make_frame(2, 2);
        commit(4'b0100);
        wait_done("busy_entry", 2000);
        check("busy_entry_wait", int'((first_rise_cyc - t0) >= 20), 1);

        busy_len = 10;
        make_frame(0, 4);
        commit(4'b0001);
        r0 = rises;
        n  = 0;
        while (rises < r0 + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_byte2", rises - r0, 2);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst tx_start", int'(bus.tx_start), 0);
        check("midrst active", int'(bus.active), 0);
        check("midrst req_ready", int'(bus.req_ready), 0);
        check("midrst grant", int'(bus.grant), NUM_REQ - 1);
        for (int r = 0; r < NUM_REQ; r++) begin
            dq[r].delete();
            gap_cnt[r] = 0;
        end
        drv_valid = '0;
        sb.delete();
        p = NUM_REQ - 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        make_frame(0, 4);
        commit(4'b0001);
        wait_done("after_reset", 2000);

`ifdef UART_TX_ARB_WATCHDOG_EN
        begin
            int stall;
            logic [7:0] b;
            b = 8'($urandom);
            sb.push_back('{1, b});
            dq[1].push_back('{b, 1'b0});
            n = 0;
            while (!(bus.active && bus.grant == GW'(1)) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("wd_grant1", int'(bus.grant), 1);
            make_frame(2, 1);
            p = 1;
            commit(4'b0100);
            stall = 0;
            n     = 0;
            do begin
                @(negedge clk);
                n++;
                if (bus.req_ready[1] && !drv_valid[1]) stall++;
            end while ((sb.size() > 0 || bus.active || drv_valid != '0) && n < 2000);
            check("wd_stall_cycles", stall, TIMEOUT);
            check("wd sb_left", sb.size(), 0);
            check("wd active", int'(bus.active), 0);
            check("wd grant", int'(bus.grant), 2);
        end
`endif

        gaps_en = 1'b1;
        repeat (30) begin
            logic [NUM_REQ-1:0] mask;
            busy_len = $urandom_range(1, 12);
            mask     = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int r = 0; r < NUM_REQ; r++) make_frame(r, $urandom_range(1, 4));
            commit(mask);
            for (int r = 0; r < NUM_REQ; r++) fr[r].delete();
            wait_done("random", 3000);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
